// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: operand/destination tags and memory status in,
// stall/flush/forward controls and event counters out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             LoadE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MispredictE;
    logic             MemReqM;
    logic             dmem_ready;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // datapath side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output LoadE, RegWriteM, RegWriteW, MispredictE, MemReqM, dmem_ready,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );

    // hazard controller side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  LoadE, RegWriteM, RegWriteW, MispredictE, MemReqM, dmem_ready,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/flow controller for a 5-stage pipeline: EX forwarding, load-use stall,
// mispredict flush, data-memory wait with timeout, saturating event counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic           clk,
    input logic           reset,
    hazard_ctrl_if.slave  bus
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              mem_err;

    logic       lw_stall;
    logic       mem_hold;
    logic       timeout;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       flush_d;
    logic       flush_e;
    logic       flush_w;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    always_comb begin
        lw_stall = bus.LoadE && (bus.RdE != '0) &&
                   ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
        // first miss cycle stalls combinationally from RUN; MEM_WAIT releases as ready arrives
        mem_hold = !bus.dmem_ready && ((state == MEM_WAIT) || bus.MemReqM);
        timeout  = (state == MEM_WAIT) && !bus.dmem_ready && (wait_cnt == WAIT_LAST);

        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;

        if (!reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (state == RUN) begin
            stall_f = lw_stall;
            stall_d = lw_stall;
            flush_e = lw_stall || bus.MispredictE;
            flush_d = bus.MispredictE;
        end
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reset) begin
            if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == bus.Rs1E))
                fwd_a = 2'b10;
            else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == bus.Rs1E))
                fwd_a = 2'b01;

            if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == bus.Rs2E))
                fwd_b = 2'b10;
            else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == bus.Rs2E))
                fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            mem_err <= timeout;

            if (stall_f && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_d && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);

            if (state == RUN) begin
                if (bus.MemReqM && !bus.dmem_ready) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= WAIT_W'(1);
                end
            end else begin
                if (bus.dmem_ready || timeout) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
        end
    end

    assign bus.StallF    = stall_f;
    assign bus.StallD    = stall_d;
    assign bus.StallE    = stall_e;
    assign bus.StallM    = stall_m;
    assign bus.FlushD    = flush_d;
    assign bus.FlushE    = flush_e;
    assign bus.FlushW    = flush_w;
    assign bus.ForwardAE = fwd_a;
    assign bus.ForwardBE = fwd_b;
    assign bus.mem_err   = mem_err;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int unsigned TO   = 4;
    localparam int unsigned CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    bit m_waiting;
    int m_waited;
    int m_stall;
    int m_flush;
    bit m_err;

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
        if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}
    function automatic logic [10:0] model_ctl();
        bit lw;
        bit hold;
        if (!reset) return 11'b0000_111_0000;
        lw   = bus.LoadE && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
        hold = !bus.dmem_ready && (m_waiting || bus.MemReqM);
        if (hold)
            return {4'b1111, 3'b001, model_fwd(bus.Rs1E), model_fwd(bus.Rs2E)};
        if (m_waiting)
            return {7'b0, model_fwd(bus.Rs1E), model_fwd(bus.Rs2E)};
        return {lw, lw, 2'b00, bus.MispredictE, lw | bus.MispredictE, 1'b0,
                model_fwd(bus.Rs1E), model_fwd(bus.Rs2E)};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                bus.FlushD, bus.FlushE, bus.FlushW, bus.ForwardAE, bus.ForwardBE};
    endfunction

    task automatic model_step();
        logic [10:0] e;
        e = model_ctl();
        if (!reset) begin
            m_waiting = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 0;
        end else begin
            if (e[10]) m_stall = (m_stall >= MAXC) ? MAXC : m_stall + 1;
            if (e[6])  m_flush = (m_flush >= MAXC) ? MAXC : m_flush + 1;
            m_err = 0;
            if (m_waiting) begin
                if (bus.dmem_ready) begin
                    m_waiting = 0;
                end else begin
                    m_waited++;
                    if (m_waited >= TO) begin
                        m_waiting = 0;
                        m_err = 1;
                    end
                end
            end else if (bus.MemReqM && !bus.dmem_ready) begin
                m_waiting = 1;
                m_waited  = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0;
        bus.RdE = '0; bus.RdM = '0; bus.RdW = '0;
        bus.LoadE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
        bus.MispredictE = 0; bus.MemReqM = 0; bus.dmem_ready = 1;
    endtask

    task automatic do_reset(input int n);
        reset = 0;
        repeat (n) tick();
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        bus.Rs1D = 5'd3; bus.Rs2D = 5'd3; bus.Rs1E = 5'd2; bus.Rs2E = 5'd2;
        bus.RdE = 5'd3; bus.RdM = 5'd2; bus.RdW = 5'd2;
        bus.LoadE = 1; bus.RegWriteM = 1; bus.RegWriteW = 1;
        bus.MispredictE = 1; bus.MemReqM = 1; bus.dmem_ready = 0;
        #1;
        checks++;
        if (obs() !== 11'b0000_111_0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs(), 11'b0000_111_0000);
        end
        tick(); tick();
        checks++;
        if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0 || bus.mem_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state stall_cnt=%0d flush_cnt=%0d mem_err=%b exp=0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.mem_err);
        end
        idle();
        reset = 1;
        tick();
    endtask

    task automatic test_forward();
        idle();
        bus.RegWriteM = 1; bus.RdM = 5'd5; bus.RegWriteW = 1; bus.RdW = 5'd5;
        bus.Rs1E = 5'd5; bus.Rs2E = 5'd7;
        #1;
        checks++;
        if (bus.ForwardAE !== 2'b10) begin
            failures++;
            $display("FAIL fwd_m_wins got=%b exp=10", bus.ForwardAE);
        end
        checks++;
        if (bus.ForwardBE !== 2'b00) begin
            failures++;
            $display("FAIL fwd_b_none got=%b exp=00", bus.ForwardBE);
        end
        bus.RdM = 5'd0;
        #1;
        checks++;
        if (bus.ForwardAE !== 2'b01) begin
            failures++;
            $display("FAIL fwd_x0_to_w got=%b exp=01", bus.ForwardAE);
        end
        bus.RdW = 5'd0;
        #1;
        checks++;
        if (bus.ForwardAE !== 2'b00) begin
            failures++;
            $display("FAIL fwd_x0_none got=%b exp=00", bus.ForwardAE);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        bus.LoadE = 1; bus.RdE = 5'd3; bus.Rs2D = 5'd3;
        #1;
        checks++;
        if (obs() !== 11'b1100_010_0000) begin
            failures++;
            $display("FAIL load_use got=%b exp=%b", obs(), 11'b1100_010_0000);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.stall_cnt !== CW'(1)) begin
            failures++;
            $display("FAIL load_use_cnt got=%0d exp=1", bus.stall_cnt);
        end
        bus.LoadE = 1; bus.RdE = 5'd0; bus.Rs1D = 5'd0;
        #1;
        checks++;
        if (bus.StallF !== 1'b0) begin
            failures++;
            $display("FAIL load_use_x0 got=%b exp=0", bus.StallF);
        end
        tick();
    endtask

    task automatic test_mispredict();
        int f0;
        idle();
        f0 = m_flush;
        bus.MispredictE = 1; bus.LoadE = 1; bus.RdE = 5'd4; bus.Rs1D = 5'd4;
        #1;
        checks++;
        if (obs() !== 11'b1100_110_0000) begin
            failures++;
            $display("FAIL mispredict got=%b exp=%b", obs(), 11'b1100_110_0000);
        end
        tick();
        idle();
        #1;
        checks++;
        if (int'(bus.flush_cnt) !== f0 + 1) begin
            failures++;
            $display("FAIL mispredict_cnt got=%0d exp=%0d", bus.flush_cnt, f0 + 1);
        end
    endtask

    task automatic test_mem_wait();
        idle();
        bus.MemReqM = 1; bus.dmem_ready = 0; bus.MispredictE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs() !== 11'b1111_001_0000) begin
                failures++;
                $display("FAIL mem_wait_c%0d got=%b exp=%b", i, obs(), 11'b1111_001_0000);
            end
            tick();
        end
        bus.dmem_ready = 1;
        #1;
        checks++;
        if (obs() !== 11'b0000_000_0000) begin
            failures++;
            $display("FAIL mem_ready got=%b exp=%b", obs(), 11'b0000_000_0000);
        end
        tick();
        idle();
        bus.dmem_ready = 0;
        #1;
        checks++;
        if (bus.StallF !== 1'b0 || bus.mem_err !== 1'b0) begin
            failures++;
            $display("FAIL mem_back_run StallF=%b mem_err=%b exp=0/0", bus.StallF, bus.mem_err);
        end
        tick();
    endtask

    task automatic test_timeout();
        idle();
        do_reset(1);
        bus.MemReqM = 1; bus.dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.StallF !== 1'b1 || bus.FlushW !== 1'b1 || bus.mem_err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_c%0d StallF=%b FlushW=%b mem_err=%b exp=1/1/0",
                         i, bus.StallF, bus.FlushW, bus.mem_err);
            end
            tick();
        end
        bus.MemReqM = 0;
        #1;
        checks++;
        if (bus.mem_err !== 1'b1 || bus.StallF !== 1'b0) begin
            failures++;
            $display("FAIL timeout_release mem_err=%b StallF=%b exp=1/0", bus.mem_err, bus.StallF);
        end
        tick();
        checks++;
        if (bus.mem_err !== 1'b0 || bus.stall_cnt !== CW'(4)) begin
            failures++;
            $display("FAIL timeout_after mem_err=%b stall_cnt=%0d exp=0/4", bus.mem_err, bus.stall_cnt);
        end
        idle();
    endtask

    task automatic test_sat_reset();
        idle();
        do_reset(1);
        bus.LoadE = 1; bus.RdE = 5'd9; bus.Rs1D = 5'd9;
        repeat (20) tick();
        checks++;
        if (bus.stall_cnt !== CW'(15)) begin
            failures++;
            $display("FAIL stall_sat got=%0d exp=15", bus.stall_cnt);
        end
        idle();
        bus.MemReqM = 1; bus.dmem_ready = 0;
        repeat (3) tick();
        reset = 0;
        #1;
        checks++;
        if (obs() !== 11'b0000_111_0000) begin
            failures++;
            $display("FAIL reset_mid_wait got=%b exp=%b", obs(), 11'b0000_111_0000);
        end
        tick();
        checks++;
        if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0 || bus.mem_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait_state stall_cnt=%0d flush_cnt=%0d mem_err=%b exp=0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.mem_err);
        end
        reset = 1;
        bus.MemReqM = 0;
        #1;
        checks++;
        if (bus.StallF !== 1'b0 || bus.FlushW !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait_run StallF=%b FlushW=%b exp=0/0", bus.StallF, bus.FlushW);
        end
        tick();
        checks++;
        if (bus.mem_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_err got=%b exp=0", bus.mem_err);
        end
        idle();
    endtask

    task automatic test_random();
        logic [10:0] e;
        for (int i = 0; i < 400; i++) begin
            reset            = ($urandom_range(0, 39) != 0);
            bus.Rs1D         = 5'($urandom_range(0, 3));
            bus.Rs2D         = 5'($urandom_range(0, 3));
            bus.Rs1E         = 5'($urandom_range(0, 3));
            bus.Rs2E         = 5'($urandom_range(0, 3));
            bus.RdE          = 5'($urandom_range(0, 3));
            bus.RdM          = 5'($urandom_range(0, 3));
            bus.RdW          = 5'($urandom_range(0, 3));
            bus.LoadE        = 1'($urandom_range(0, 1));
            bus.RegWriteM    = 1'($urandom_range(0, 1));
            bus.RegWriteW    = 1'($urandom_range(0, 1));
            bus.MispredictE  = ($urandom_range(0, 3) == 0);
            bus.MemReqM      = ($urandom_range(0, 2) == 0);
            bus.dmem_ready   = ($urandom_range(0, 2) == 0);
            #1;
            e = model_ctl();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL rand_ctl i=%0d got=%b exp=%b", i, obs(), e);
            end
            tick();
            checks++;
            if (int'(bus.stall_cnt) !== m_stall || int'(bus.flush_cnt) !== m_flush ||
                bus.mem_err !== 1'(m_err)) begin
                failures++;
                $display("FAIL rand_state i=%0d stall=%0d/%0d flush=%0d/%0d err=%b/%b (got/exp)",
                         i, bus.stall_cnt, m_stall, bus.flush_cnt, m_flush, bus.mem_err, m_err);
            end
        end
        reset = 1;
        idle();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_waiting = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 0;
        reset = 0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_mispredict();
        test_mem_wait();
        test_timeout();
        test_sat_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
